// File: rtl/mems_spi_pkg.sv
// Shared definitions for the MEMS DAC SPI transmitter: FSM states and parameter defaults.
package mems_spi_pkg;

  localparam int CLK_DIV_DEF    = 4;
  localparam int WORD_W_DEF     = 24;
  localparam int GAP_CYCLES_DEF = 2;

  // Half-period counter width; covers CLK_DIV up to 255.
  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  // Bit counter must hold the value WORD_W itself (hold-phase marker).
  function automatic int bit_cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/mems_spi_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV enabled cycles, restartable on phase change.
module mems_spi_tick
  import mems_spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (restart || !en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // With CLK_DIV=1 LAST is zero, so every enabled cycle ticks.
  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/mems_spi_tx.sv
// SPI frame transmitter for a MEMS driver DAC (sync_n/sclk/mosi, MSB first, sclk idles high).
// Optional inter-frame gap state compiled in when MEMS_SPI_GAP_EN is defined.
module mems_spi_tx
  import mems_spi_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              sync_n,
  output logic              sclk,
  output logic              mosi
);

  localparam int BIT_W = bit_cnt_w(WORD_W);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(WORD_W);

  localparam bit GAP_EN =
`ifdef MEMS_SPI_GAP_EN
    1'b1;
`else
    1'b0;
`endif
  localparam int GAP_LEN = GAP_EN ? GAP_CYCLES : 0;

  state_t            state_reg, state_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              sync_n_reg, sync_n_next;
  logic              sclk_reg, sclk_next;
  logic              mosi_reg, mosi_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0] shifted;
  logic              tick;
  logic              tick_en;
  logic              phase_change;

  assign shifted = shift_reg << 1;
  assign tick_en = (state_reg == SETUP) || (state_reg == SHIFT_LO) || (state_reg == SHIFT_HI);

  mems_spi_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_en),
    .restart(phase_change),
    .tick   (tick)
  );

`ifdef MEMS_SPI_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  logic [GAP_W-1:0] gap_cnt_reg;
  logic             gap_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_reg <= '0;
    end else if (state_reg == GAP) begin
      gap_cnt_reg <= gap_cnt_reg + 1'b1;
    end else begin
      gap_cnt_reg <= '0;
    end
  end

  assign gap_last = (gap_cnt_reg == GAP_W'(GAP_LEN - 1));
`endif

  always_comb begin
    state_next   = state_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    sync_n_next  = sync_n_reg;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    phase_change = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = SETUP;
          busy_next    = 1'b1;
          sync_n_next  = 1'b0;
          sclk_next    = 1'b1;
          mosi_next    = data[WORD_W-1];
          shift_next   = data;
          bit_cnt_next = '0;
          phase_change = 1'b1;
        end
      end

      SETUP: begin
        if (tick) begin
          phase_change = 1'b1;
          sclk_next    = 1'b0;
          state_next   = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (tick) begin
          phase_change = 1'b1;
          sclk_next    = 1'b1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          state_next   = SHIFT_HI;
          // After the last low half mosi keeps the LSB through the hold phase.
          if (bit_cnt_reg != LAST_IDX) begin
            shift_next = shifted;
            mosi_next  = shifted[WORD_W-1];
          end
        end
      end

      SHIFT_HI: begin
        if (tick) begin
          phase_change = 1'b1;
          if (bit_cnt_reg == ALL_BITS) begin
            sync_n_next = 1'b1;
            if (GAP_LEN > 0) begin
              state_next = GAP;
            end else begin
              busy_next  = 1'b0;
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end else begin
            sclk_next  = 1'b0;
            state_next = SHIFT_LO;
          end
        end
      end

`ifdef MEMS_SPI_GAP_EN
      GAP: begin
        if (gap_last) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
`endif

      default: begin
        state_next  = IDLE;
        busy_next   = 1'b0;
        sync_n_next = 1'b1;
        sclk_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      sync_n_reg  <= 1'b1;
      sclk_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      sync_n_reg  <= sync_n_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign sync_n = sync_n_reg;
  assign sclk   = sclk_reg;
  assign mosi   = mosi_reg;

endmodule
